obi_demux_1_to_n: RTL and testbench

OBI_DEMUX_1_TO_N -- requirements
Module: obi_demux_1_to_n

---
 rtl/obi_demux_1_to_n.sv | 189 ++++++++++++++++++
 tb/tb_obi_demux_1_to_n.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_demux_1_to_n.sv
// obi_demux_1_to_n
// One OBI manager fanned out to NUM_PORTS subordinates by address range.
// Request fields are broadcast to every port, and only the decoded port sees
// req. Responses return in order through a small FIFO of target ids. New
// requests stall while the FIFO is full or while the new target differs from
// the one still in flight. Addresses outside every range get a local
// 32'hDEADBEEF response one cycle after acceptance.
//
// Optional feature macro: OBI_DEMUX_ERR_RESP_EN
//   defined   -> responses to unmapped accesses also assert ctrl_err_o
//   undefined -> ctrl_err_o is tied low
module obi_demux_1_to_n #(
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [NUM_PORTS*32-1:0] PORT_BASE_ADDRS =
    {32'h80000000, 32'h00003000, 32'h00002000, 32'h00001000},
  parameter logic [NUM_PORTS*32-1:0] PORT_END_ADDRS =
    {32'h8000ffff, 32'h00003fff, 32'h00002fff, 32'h00001fff}
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    ctrl_req_i,
  output logic                    ctrl_gnt_o,
  input  logic [31:0]             ctrl_addr_i,
  input  logic                    ctrl_we_i,
  input  logic [3:0]              ctrl_be_i,
  input  logic [31:0]             ctrl_wdata_i,
  output logic                    ctrl_rvalid_o,
  output logic [31:0]             ctrl_rdata_o,
  output logic                    ctrl_err_o,

  output logic [NUM_PORTS-1:0]    port_req_o,
  input  logic [NUM_PORTS-1:0]    port_gnt_i,
  output logic [NUM_PORTS*32-1:0] port_addr_o,
  output logic [NUM_PORTS-1:0]    port_we_o,
  output logic [NUM_PORTS*4-1:0]  port_be_o,
  output logic [NUM_PORTS*32-1:0] port_wdata_o,
  input  logic [NUM_PORTS-1:0]    port_rvalid_i,
  input  logic [NUM_PORTS*32-1:0] port_rdata_i,

  output logic                    bad_state_o,
  output logic                    spurious_rsp_o
);

  // Target ids 0..NUM_PORTS-1 are real ports; NUM_PORTS marks "unmapped".
  localparam int unsigned ID_W  = $clog2(NUM_PORTS + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [ID_W-1:0]  UNMAPPED_ID = ID_W'(NUM_PORTS);
  localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_OUTSTANDING);
  localparam logic [31:0]      UNMAPPED_RDATA = 32'hDEADBEEF;

  logic [ID_W-1:0]  sel;
  logic             mapped;
  logic             stall;
  logic             gnt_raw;
  logic             accept;
  logic             pop;
  logic             spurious_hit;

  logic [ID_W-1:0]  fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [ID_W-1:0]  head;
  logic [ID_W-1:0]  last_id;
  logic             err_pending;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign head = fifo[rd_ptr];

  // Address decode; walking downwards lets the lowest matching index win.
  always_comb begin
    sel    = UNMAPPED_ID;
    mapped = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((ctrl_addr_i >= PORT_BASE_ADDRS[i*32 +: 32]) &&
          (ctrl_addr_i <= PORT_END_ADDRS[i*32 +: 32])) begin
        sel    = ID_W'(i);
        mapped = 1'b1;
      end
    end
  end

  // Hold off while full, or while in-flight responses belong to another
  // target, so responses can never return out of order.
  always_comb begin
    stall = (count == MAX_CNT) || ((count != '0) && (sel != last_id));
  end

  // Grant and per-port request; both are forced low while reset is applied.
  always_comb begin
    gnt_raw    = ~mapped;
    port_req_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel == ID_W'(i)) begin
        gnt_raw       = port_gnt_i[i];
        port_req_o[i] = rst_ni & ctrl_req_i & ~stall;
      end
    end
    ctrl_gnt_o = rst_ni & ~stall & gnt_raw;
  end

  assign accept      = ctrl_req_i & ctrl_gnt_o;
  assign bad_state_o = ctrl_req_i & ~mapped;

  assign port_addr_o  = {NUM_PORTS{ctrl_addr_i}};
  assign port_we_o    = {NUM_PORTS{ctrl_we_i}};
  assign port_be_o    = {NUM_PORTS{ctrl_be_i}};
  assign port_wdata_o = {NUM_PORTS{ctrl_wdata_i}};

  // Response mux driven by the target id at the FIFO head.
  always_comb begin
    ctrl_rvalid_o = 1'b0;
    ctrl_rdata_o  = '0;
    ctrl_err_o    = 1'b0;
    if (count != '0) begin
      if (head == UNMAPPED_ID) begin
        if (err_pending) begin
          ctrl_rvalid_o = 1'b1;
          ctrl_rdata_o  = UNMAPPED_RDATA;
`ifdef OBI_DEMUX_ERR_RESP_EN
          ctrl_err_o    = 1'b1;
`endif
        end
      end else begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (head == ID_W'(i)) begin
            ctrl_rvalid_o = port_rvalid_i[i];
            ctrl_rdata_o  = port_rdata_i[i*32 +: 32];
          end
        end
      end
    end
  end

  assign pop = ctrl_rvalid_o;

  // Any port response that does not belong to the FIFO head is dropped.
  always_comb begin
    spurious_hit = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port_rvalid_i[i] && ((count == '0) || (head != ID_W'(i)))) begin
        spurious_hit = 1'b1;
      end
    end
  end

  // Target-id storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo[wr_ptr] <= sel;
    end
  end

  // FIFO pointers, occupancy, local-response flag and spurious pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      last_id        <= UNMAPPED_ID;
      err_pending    <= 1'b0;
      spurious_rsp_o <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr  <= ptr_inc(wr_ptr);
        last_id <= sel;
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      err_pending    <= accept & ~mapped;
      spurious_rsp_o <= spurious_hit;
    end
  end

endmodule

// File: tb/tb_obi_demux_1_to_n.sv
// Testbench for obi_demux_1_to_n (default parameters). Expected behaviour
// comes from an address-range table and a queue of in-flight transactions
// tagged with their acceptance cycle.
module tb_obi_demux_1_to_n;

`ifdef OBI_DEMUX_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int NP   = 4;
  localparam int MAXO = 2;
  localparam int UNM  = 4;

  logic [31:0] bases [NP] = '{32'h00001000, 32'h00002000, 32'h00003000, 32'h80000000};
  logic [31:0] ends   [NP] = '{32'h00001fff, 32'h00002fff, 32'h00003fff, 32'h8000ffff};

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          ctrl_req_i;
  logic          ctrl_gnt_o;
  logic [31:0]   ctrl_addr_i;
  logic          ctrl_we_i;
  logic [3:0]    ctrl_be_i;
  logic [31:0]   ctrl_wdata_i;
  logic          ctrl_rvalid_o;
  logic [31:0]   ctrl_rdata_o;
  logic          ctrl_err_o;
  logic [3:0]    port_req_o;
  logic [3:0]    port_gnt_i;
  logic [127:0]  port_addr_o;
  logic [3:0]    port_we_o;
  logic [15:0]   port_be_o;
  logic [127:0]  port_wdata_o;
  logic [3:0]    port_rvalid_i;
  logic [127:0]  port_rdata_i;
  logic          bad_state_o;
  logic          spurious_rsp_o;

  obi_demux_1_to_n dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ctrl_req_i(ctrl_req_i), .ctrl_gnt_o(ctrl_gnt_o), .ctrl_addr_i(ctrl_addr_i),
    .ctrl_we_i(ctrl_we_i), .ctrl_be_i(ctrl_be_i), .ctrl_wdata_i(ctrl_wdata_i),
    .ctrl_rvalid_o(ctrl_rvalid_o), .ctrl_rdata_o(ctrl_rdata_o), .ctrl_err_o(ctrl_err_o),
    .port_req_o(port_req_o), .port_gnt_i(port_gnt_i), .port_addr_o(port_addr_o),
    .port_we_o(port_we_o), .port_be_o(port_be_o), .port_wdata_o(port_wdata_o),
    .port_rvalid_i(port_rvalid_i), .port_rdata_i(port_rdata_i),
    .bad_state_o(bad_state_o), .spurious_rsp_o(spurious_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int id;
    int cyc;
  } ent_t;

  ent_t q[$];
  int   cyc_no = 0;
  int   m_last = UNM;
  bit   m_spur = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NP; i++)
      if (a >= bases[i] && a <= ends[i]) return i;
    return UNM;
  endfunction

  // One bus cycle: drive at negedge, check combinational and registered
  // outputs shortly after, then advance the model at the rising edge.
  task automatic cycle(input bit req, input logic [31:0] addr, input logic [3:0] gnt,
                       input logic [3:0] rv, input logic [127:0] rd);
    int tgt, cnt, k;
    bit busy, e_gnt, e_rv, e_err, unm_rsp, spur_next;
    logic [3:0]  e_req;
    logic [31:0] e_rd;
    @(negedge clk_i);
    ctrl_req_i    = req;
    ctrl_addr_i   = addr;
    ctrl_we_i     = 1'($urandom);
    ctrl_be_i     = 4'($urandom);
    ctrl_wdata_i  = $urandom;
    port_gnt_i    = gnt;
    port_rvalid_i = rv;
    port_rdata_i  = rd;
    #1;
    tgt   = decode(addr);
    cnt   = q.size();
    busy  = (cnt == MAXO) || (cnt > 0 && tgt != m_last);
    e_gnt = !busy && ((tgt == UNM) ? 1'b1 : gnt[tgt]);
    e_req = '0;
    if (req && !busy && tgt != UNM) e_req[tgt] = 1'b1;
    unm_rsp = 1'b0;
    e_rv = 1'b0;
    e_rd = '0;
    if (cnt > 0) begin
      if (q[0].id == UNM) begin
        unm_rsp = (cyc_no == q[0].cyc + 1);
        e_rv = unm_rsp;
        e_rd = 32'hDEADBEEF;
      end else begin
        e_rv = rv[q[0].id];
        e_rd = rd[q[0].id*32 +: 32];
      end
    end
    e_err = ERR_EN && unm_rsp;
    spur_next = 1'b0;
    for (int i = 0; i < NP; i++)
      if (rv[i] && (cnt == 0 || q[0].id != i)) spur_next = 1'b1;

    check("gnt", 32'(ctrl_gnt_o), 32'(e_gnt));
    check("port_req", 32'(port_req_o), 32'(e_req));
    check("bad_state", 32'(bad_state_o), 32'(req && tgt == UNM));
    check("rvalid", 32'(ctrl_rvalid_o), 32'(e_rv));
    if (e_rv || cnt == 0) check("rdata", ctrl_rdata_o, e_rd);
    check("err", 32'(ctrl_err_o), 32'(e_err));
    check("spurious", 32'(spurious_rsp_o), 32'(m_spur));
    check("count", 32'(dut.count), 32'(cnt));
    k = $urandom_range(0, NP - 1);
    check("bcast_addr", port_addr_o[k*32 +: 32], addr);
    check("bcast_ctl", {port_we_o[k], port_be_o[k*4 +: 4], port_wdata_o[k*32 +: 27]},
          {ctrl_we_i, ctrl_be_i, ctrl_wdata_i[26:0]});

    @(posedge clk_i);
    if (e_rv) void'(q.pop_front());
    if (req && e_gnt) begin
      q.push_back('{id: tgt, cyc: cyc_no});
      m_last = tgt;
    end
    m_spur = spur_next;
    cyc_no++;
  endtask

  function automatic logic [127:0] rnd_rdata();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] rnd_addr();
    int r, j;
    r = $urandom_range(0, 5);
    j = $urandom_range(0, NP - 1);
    if (r < 4) return bases[r] + $urandom_range(0, ends[r] - bases[r]);
    if (r == 4) return 32'($urandom_range(0, 32'h0fff));
    case ($urandom_range(0, 3))
      0: return bases[j];
      1: return ends[j];
      2: return bases[j] - 1;
      default: return ends[j] + 1;
    endcase
  endfunction

  task automatic rand_cycle();
    logic [3:0] rv;
    rv = '0;
    if (q.size() > 0 && q[0].id != UNM && $urandom_range(0, 1) == 1) rv[q[0].id] = 1'b1;
    if ($urandom_range(0, 9) == 0) rv[$urandom_range(0, NP - 1)] = 1'b1;
    cycle($urandom_range(0, 3) != 0, rnd_addr(), 4'($urandom), rv, rnd_rdata());
  endtask

  task automatic reset_model();
    q.delete();
    m_spur = 1'b0;
    m_last = UNM;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rd;
    rst_ni        = 1'b0;
    ctrl_req_i    = 1'b1;
    ctrl_addr_i   = 32'h00001000;
    ctrl_we_i     = 1'b0;
    ctrl_be_i     = 4'hf;
    ctrl_wdata_i  = '0;
    port_gnt_i    = 4'hf;
    port_rvalid_i = 4'b0010;
    port_rdata_i  = '0;
    #3;
    check("rst_gnt", 32'(ctrl_gnt_o), 32'd0);
    check("rst_port_req", 32'(port_req_o), 32'd0);
    check("rst_rvalid", 32'(ctrl_rvalid_o), 32'd0);
    check("rst_err", 32'(ctrl_err_o), 32'd0);
    check("rst_spurious", 32'(spurious_rsp_o), 32'd0);
    check("rst_count", 32'(dut.count), 32'd0);
    @(negedge clk_i);
    port_rvalid_i = '0;
    ctrl_req_i    = 1'b0;
    rst_ni        = 1'b1;
    reset_model();

    // Single read to port 1 region, response two cycles later.
    rd = '0;
    rd[32 +: 32] = 32'h12345678;
    cycle(1, 32'h00002004, 4'b0010, 4'b0000, '0);
    cycle(0, 32'h0, 4'b0000, 4'b0000, '0);
    cycle(0, 32'h0, 4'b0000, 4'b0010, rd);
    cycle(0, 32'h0, 4'b0000, 4'b0000, '0);

    // Fill to the limit, third request held until a slot frees.
    cycle(1, 32'h00001000, 4'b0001, 4'b0000, rnd_rdata());
    cycle(1, 32'h00001004, 4'b0001, 4'b0000, rnd_rdata());
    cycle(1, 32'h00001008, 4'b0001, 4'b0000, rnd_rdata());
    cycle(1, 32'h00001008, 4'b0001, 4'b0001, rnd_rdata());
    cycle(1, 32'h00001008, 4'b0001, 4'b0000, rnd_rdata());
    cycle(0, 32'h0, 4'b0000, 4'b0001, rnd_rdata());
    cycle(0, 32'h0, 4'b0000, 4'b0001, rnd_rdata());

    // Target switch waits for the outstanding port 0 response.
    cycle(1, 32'h00001000, 4'b0001, 4'b0000, rnd_rdata());
    cycle(1, 32'h80000010, 4'b1111, 4'b0000, rnd_rdata());
    cycle(1, 32'h80000010, 4'b1111, 4'b0001, rnd_rdata());
    cycle(1, 32'h80000010, 4'b1111, 4'b0000, rnd_rdata());
    cycle(0, 32'h0, 4'b0000, 4'b1000, rnd_rdata());

    // Unmapped read answered locally one cycle later; then back-to-back.
    cycle(1, 32'h00000000, 4'b0000, 4'b0000, rnd_rdata());
    cycle(1, 32'h00000ffc, 4'b0000, 4'b0000, rnd_rdata());
    cycle(0, 32'h0, 4'b0000, 4'b0000, rnd_rdata());
    cycle(0, 32'h0, 4'b0000, 4'b0000, rnd_rdata());

    // Response with nothing outstanding.
    cycle(0, 32'h0, 4'b0000, 4'b0010, rnd_rdata());
    cycle(0, 32'h0, 4'b0000, 4'b0000, rnd_rdata());
    cycle(0, 32'h0, 4'b0000, 4'b0000, rnd_rdata());

    // Reset mid-transaction, then a late response.
    cycle(1, 32'h00001000, 4'b0001, 4'b0000, rnd_rdata());
    cycle(1, 32'h00001004, 4'b0001, 4'b0000, rnd_rdata());
    @(negedge clk_i);
    ctrl_req_i    = 1'b1;
    ctrl_addr_i   = 32'h00001000;
    port_gnt_i    = 4'hf;
    port_rvalid_i = 4'b0000;
    #2 rst_ni = 1'b0;
    #1;
    check("midrst_count", 32'(dut.count), 32'd0);
    check("midrst_gnt", 32'(ctrl_gnt_o), 32'd0);
    check("midrst_port_req", 32'(port_req_o), 32'd0);
    check("midrst_rvalid", 32'(ctrl_rvalid_o), 32'd0);
    reset_model();
    @(negedge clk_i);
    ctrl_req_i = 1'b0;
    rst_ni     = 1'b1;
    cycle(0, 32'h0, 4'b0000, 4'b0001, rnd_rdata());
    cycle(0, 32'h0, 4'b0000, 4'b0000, rnd_rdata());

    for (int n = 0; n < 3000; n++) rand_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
